// File: rtl/chacha_pkg.sv
// Shared constants, quarter-round schedule and FSM encoding for the ChaCha20
// block controller.
package chacha_pkg;

    // "expand 32-byte k" constants, state words 0..3
    localparam logic [0:3][31:0] SIGMA = {
        32'h6170_7865, 32'h3320_646e, 32'h7962_2d32, 32'h6b20_6574
    };

    // Word indices (a,b,c,d) for each quarter-round, indexed by
    // {round parity, qr_idx}: rows 0-3 are column rounds, rows 4-7 diagonal.
    localparam logic [0:7][0:3][3:0] QR_TABLE = {
        4'd0, 4'd4, 4'd8,  4'd12,
        4'd1, 4'd5, 4'd9,  4'd13,
        4'd2, 4'd6, 4'd10, 4'd14,
        4'd3, 4'd7, 4'd11, 4'd15,
        4'd0, 4'd5, 4'd10, 4'd15,
        4'd1, 4'd6, 4'd11, 4'd12,
        4'd2, 4'd7, 4'd8,  4'd13,
        4'd3, 4'd4, 4'd9,  4'd14
    };

    // Quarter-round rotate amounts, in order of application
    localparam int unsigned ROT_0 = 16;
    localparam int unsigned ROT_1 = 12;
    localparam int unsigned ROT_2 = 8;
    localparam int unsigned ROT_3 = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_ADD   = 3'd3,
        ST_OUT   = 3'd4,
        ST_FIN   = 3'd5
    } state_e;

    // 32-bit rotate left; n is always in 1..31 here
    function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter-round: (a,b,c,d) -> (a',b',c',d').
module chacha_qr
    import chacha_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o
);

    logic [31:0] a1_s, b1_s, c1_s, d1_s;
    logic [31:0] a2_s, b2_s, c2_s, d2_s;

    // Two add-xor-rotate half steps; all additions wrap mod 2^32
    always_comb begin
        a1_s = a_i + b_i;
        d1_s = rotl32(d_i ^ a1_s, ROT_0);
        c1_s = c_i + d1_s;
        b1_s = rotl32(b_i ^ c1_s, ROT_1);
        a2_s = a1_s + b1_s;
        d2_s = rotl32(d1_s ^ a2_s, ROT_2);
        c2_s = c1_s + d2_s;
        b2_s = rotl32(b1_s ^ c2_s, ROT_3);
        a_o  = a2_s;
        b_o  = b2_s;
        c_o  = c2_s;
        d_o  = d2_s;
    end

endmodule

// File: rtl/chacha_block_ctrl.sv
// ChaCha20 keystream block sequencer: captures a request, runs the shared
// quarter-round unit through the round schedule, adds the feed-forward and
// hands out consecutive 512-bit blocks on a valid/ready interface.
module chacha_block_ctrl
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  ctr_init,
    input  logic [15:0]  num_blocks,
    input  logic         ks_ready,
    output logic         busy,
    output logic         ks_valid,
    output logic [511:0] ks_data,
    output logic         done,
    output logic         ctr_wrap
);

    localparam int RW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;

    state_e          state_q, state_d;
    logic [255:0]    key_q, key_d;
    logic [95:0]     nonce_q, nonce_d;
    logic [31:0]     ctr_q, ctr_d;
    logic [15:0]     left_q, left_d;
    logic [31:0]     x_q [16];
    logic [31:0]     x_d [16];
    logic [1:0]      qr_idx_q, qr_idx_d;
    logic [RW-1:0]   round_q, round_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            wrap_q, wrap_d;
    logic [511:0]    data_q, data_d;

    logic [31:0]     init_s [16];
    logic [2:0]      sel_s;
    logic [3:0]      ia_s, ib_s, ic_s, id_s;
    logic [31:0]     qa_s, qb_s, qc_s, qd_s;
    logic [511:0]    sum_s;

    // Initial matrix, rebuilt from the captured request; key, nonce and
    // counter stay stable for the whole life of a block, so no copy is stored.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            init_s[i] = SIGMA[i];
        end
        for (int i = 0; i < 8; i++) begin
            init_s[4 + i] = key_q[32*i +: 32];
        end
        init_s[12] = ctr_q;
        for (int i = 0; i < 3; i++) begin
            init_s[13 + i] = nonce_q[32*i +: 32];
        end
    end

    // 4-of-16 operand select in front of the shared quarter-round
    always_comb begin
        sel_s = {round_q[0], qr_idx_q};
        ia_s  = QR_TABLE[sel_s][0];
        ib_s  = QR_TABLE[sel_s][1];
        ic_s  = QR_TABLE[sel_s][2];
        id_s  = QR_TABLE[sel_s][3];
    end

    chacha_qr u_qr (
        .a_i (x_q[ia_s]),
        .b_i (x_q[ib_s]),
        .c_i (x_q[ic_s]),
        .d_i (x_q[id_s]),
        .a_o (qa_s),
        .b_o (qb_s),
        .c_o (qc_s),
        .d_o (qd_s)
    );

    // Feed-forward addition of the working state and the initial matrix
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sum_s[32*i +: 32] = x_q[i] + init_s[i];
        end
    end

    // Next-state and registered-output logic for the block sequencer
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        nonce_d  = nonce_q;
        ctr_d    = ctr_q;
        left_d   = left_q;
        x_d      = x_q;
        qr_idx_d = qr_idx_q;
        round_d  = round_q;
        data_d   = data_q;
        wrap_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key;
                    nonce_d = nonce;
                    ctr_d   = ctr_init;
                    left_d  = num_blocks;
                    if (num_blocks == 16'd0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                x_d      = init_s;
                qr_idx_d = 2'd0;
                round_d  = '0;
                state_d  = ST_ROUND;
            end
            ST_ROUND: begin
                x_d[ia_s] = qa_s;
                x_d[ib_s] = qb_s;
                x_d[ic_s] = qc_s;
                x_d[id_s] = qd_s;
                qr_idx_d  = qr_idx_q + 2'd1;
                if (qr_idx_q == 2'd3) begin
                    if (round_q == RW'(ROUNDS - 1)) begin
                        state_d = ST_ADD;
                    end else begin
                        round_d = round_q + RW'(1);
                    end
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ADD: begin
                data_d  = sum_s;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (ks_ready) begin
                    ctr_d  = ctr_q + 32'd1;
                    wrap_d = (ctr_q == 32'hFFFF_FFFF);
                    left_d = left_q - 16'd1;
                    if (left_q == 16'd1) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d == ST_LOAD) || (state_d == ST_ROUND) ||
                  (state_d == ST_ADD)  || (state_d == ST_OUT);
        valid_d = (state_d == ST_OUT);
        done_d  = (state_d == ST_FIN);
    end

    // State and output registers; reset aborts any block in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            key_q    <= 256'd0;
            nonce_q  <= 96'd0;
            ctr_q    <= 32'd0;
            left_q   <= 16'd0;
            for (int i = 0; i < 16; i++) begin
                x_q[i] <= 32'd0;
            end
            qr_idx_q <= 2'd0;
            round_q  <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            data_q   <= 512'd0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            nonce_q  <= nonce_d;
            ctr_q    <= ctr_d;
            left_q   <= left_d;
            x_q      <= x_d;
            qr_idx_q <= qr_idx_d;
            round_q  <= round_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
            data_q   <= data_d;
        end
    end

    assign busy     = busy_q;
    assign ks_valid = valid_q;
    assign ks_data  = data_q;
    assign done     = done_q;
    assign ctr_wrap = wrap_q;

endmodule

// File: tb/tb_chacha_block_ctrl.sv
// Self-checking bench for chacha_block_ctrl: table of requests scored
// against an independent ChaCha20 block model, plus hand-written sequences
// for back-pressure, ignored start, and reset mid-operation.
module tb_chacha_block_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [255:0] key;
    logic [95:0]  nonce = 96'h00000000_4a000000_09000000;
    logic [31:0]  ctr_init = 32'd0;
    logic [15:0]  num_blocks = 16'd0;
    logic         ks_ready = 1'b0;
    logic         busy, ks_valid, done, ctr_wrap;
    logic [511:0] ks_data;

    chacha_block_ctrl #(.ROUNDS(20)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .nonce(nonce),
        .ctr_init(ctr_init), .num_blocks(num_blocks), .ks_ready(ks_ready),
        .busy(busy), .ks_valid(ks_valid), .ks_data(ks_data), .done(done),
        .ctr_wrap(ctr_wrap)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [511:0] exp_q[$];
    int blk_cnt, wrap_cnt, done_cnt, valid_cnt;
    int first_rise, last_rise, done_cyc, last_hs, start_cyc;
    bit gap_en;
    logic [511:0] first_data;
    logic prev_valid = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] ctr;
        logic [15:0] nb;
        int          exp_blocks;
        int          exp_wraps;
        bit          rfc;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] tqr(input logic [31:0] a0, b0, c0, d0);
        logic [31:0] a, b, c, d;
        a = a0; b = b0; c = c0; d = d0;
        a = a + b; d = rl(d ^ a, 16);
        c = c + d; b = rl(b ^ c, 12);
        a = a + b; d = rl(d ^ a, 8);
        c = c + d; b = rl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Reference ChaCha20 block function (10 double rounds)
    function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                               input logic [31:0] c);
        logic [31:0] s[16];
        logic [31:0] w[16];
        logic [511:0] r;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13 + i] = n[32*i +: 32];
        w = s;
        for (int r2 = 0; r2 < 10; r2++) begin
            {w[0], w[4], w[8],  w[12]} = tqr(w[0], w[4], w[8],  w[12]);
            {w[1], w[5], w[9],  w[13]} = tqr(w[1], w[5], w[9],  w[13]);
            {w[2], w[6], w[10], w[14]} = tqr(w[2], w[6], w[10], w[14]);
            {w[3], w[7], w[11], w[15]} = tqr(w[3], w[7], w[11], w[15]);
            {w[0], w[5], w[10], w[15]} = tqr(w[0], w[5], w[10], w[15]);
            {w[1], w[6], w[11], w[12]} = tqr(w[1], w[6], w[11], w[12]);
            {w[2], w[7], w[8],  w[13]} = tqr(w[2], w[7], w[8],  w[13]);
            {w[3], w[4], w[9],  w[14]} = tqr(w[3], w[4], w[9],  w[14]);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i] + s[i];
        return r;
    endfunction

    // Output monitor: scoreboard pops on each handshake, pulse and gap tracking
    always @(negedge clk) begin
        if (rst) begin
            if (ks_valid) valid_cnt++;
            if (ks_valid && !prev_valid) begin
                if (first_rise < 0) first_rise = cyc;
                else if (gap_en) chk("block gap", 512'(cyc - last_rise), 512'd83);
                last_rise = cyc;
            end
            if (ks_valid && ks_ready) begin
                if (blk_cnt == 0) first_data = ks_data;
                blk_cnt++;
                last_hs = cyc;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected block: got %0h expected none", ks_data);
                end else begin
                    chk("block data", ks_data, exp_q.pop_front());
                end
            end
            if (ctr_wrap) wrap_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy low with done", 512'(busy), 512'd0);
            end
        end
        prev_valid = ks_valid;
    end

    task automatic clr();
        blk_cnt = 0; wrap_cnt = 0; done_cnt = 0; valid_cnt = 0;
        first_rise = -1; last_rise = 0; done_cyc = 0; last_hs = 0;
        gap_en = 0; first_data = '0;
    endtask

    task automatic do_start(input logic [31:0] c, input logic [15:0] nb);
        @(posedge clk); #1;
        ctr_init = c; num_blocks = nb; start = 1'b1;
        for (int i = 0; i < int'(nb); i++) exp_q.push_back(ref_block(key, nonce, c + 32'(i)));
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        clr();
        gap_en = (v.nb > 16'd1);
        ks_ready = 1'b1;
        do_start(v.ctr, v.nb);
        chk({v.name, " busy after start"}, 512'(busy), 512'(v.nb != 16'd0));
        wait_done(100 * (int'(v.nb) + 1));
        chk({v.name, " done pulses"}, 512'(done_cnt), 512'd1);
        chk({v.name, " blocks"}, 512'(blk_cnt), 512'(v.exp_blocks));
        chk({v.name, " wraps"}, 512'(wrap_cnt), 512'(v.exp_wraps));
        chk({v.name, " scoreboard empty"}, 512'(exp_q.size()), 512'd0);
        if (v.exp_blocks == 0) begin
            chk({v.name, " no valid"}, 512'(valid_cnt), 512'd0);
            chk({v.name, " done latency"}, 512'(done_cyc - start_cyc), 512'd0);
        end else begin
            chk({v.name, " first latency"}, 512'(first_rise - start_cyc), 512'd82);
            chk({v.name, " done after handshake"}, 512'(done_cyc - last_hs), 512'd1);
        end
        if (v.rfc) begin
            chk("rfc word0", 512'(first_data[31:0]), 512'(32'he4e7f110));
            chk("rfc word1", 512'(first_data[63:32]), 512'(32'h15593bd1));
        end
        exp_q.delete();
    endtask

    initial begin
        int bad;
        logic [511:0] held;
        for (int j = 0; j < 32; j++) key[8*j +: 8] = 8'(j);
        vecs[0] = '{"rfc",   32'd1,           16'd1, 1, 0, 1'b1};
        vecs[1] = '{"multi", 32'd1,           16'd3, 3, 0, 1'b0};
        vecs[2] = '{"wrap",  32'hFFFF_FFFF,   16'd2, 2, 1, 1'b0};
        vecs[3] = '{"zero",  32'd5,           16'd0, 0, 0, 1'b0};
        clr();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {ks_data, busy, ks_valid, done, ctr_wrap}, '0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int t = 0; t < 4; t++) run_vec(vecs[t]);

        // Back-pressure: block held 50 cycles, then accepted on first ready edge
        clr();
        ks_ready = 1'b0;
        do_start(32'd7, 16'd2);
        for (int i = 0; i < 200 && !ks_valid; i++) begin @(posedge clk); #1; end
        chk("bp valid", 512'(ks_valid), 512'd1);
        held = ks_data;
        bad = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (ks_valid !== 1'b1 || ks_data !== held) bad++;
        end
        chk("bp hold", 512'(bad), 512'd0);
        chk("bp no block yet", 512'(blk_cnt), 512'd0);
        ks_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp accepted first edge", 512'(ks_valid), 512'd0);
        wait_done(300);
        chk("bp blocks", 512'(blk_cnt), 512'd2);
        chk("bp scoreboard empty", 512'(exp_q.size()), 512'd0);
        exp_q.delete();

        // start pulsed mid-ROUND is ignored
        clr();
        do_start(32'd1, 16'd1);
        repeat (30) @(posedge clk);
        #1;
        key = ~key; ctr_init = 32'h1234_5678; num_blocks = 16'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j < 32; j++) key[8*j +: 8] = 8'(j);
        wait_done(300);
        repeat (100) @(posedge clk);
        #1;
        chk("ignored start blocks", 512'(blk_cnt), 512'd1);
        chk("ignored start done", 512'(done_cnt), 512'd1);
        chk("ignored start data", first_data, ref_block(key, nonce, 32'd1));
        chk("ignored start idle", 512'(busy), 512'd0);
        exp_q.delete();

        // Reset at cycle 40 of ROUND
        clr();
        do_start(32'd1, 16'd1);
        repeat (41) @(posedge clk);
        #1;
        chk("busy before reset", 512'(busy), 512'd1);
        rst = 1'b0;
        #1;
        chk("outputs at reset", {ks_data, busy, ks_valid, done, ctr_wrap}, '0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (150) @(posedge clk);
        #1;
        chk("no done after reset", 512'(done_cnt), 512'd0);
        chk("no block after reset", 512'(blk_cnt), 512'd0);
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chacha_block_ctrl.md
# chacha_block_ctrl

Sequencing controller for the ChaCha20 keystream datapath. It captures key, nonce and initial block counter on a start request and runs one shared quarter-round unit through the 20-round column/diagonal schedule. It then applies the feed-forward addition and presents each 512-bit keystream block on a valid/ready handshake. It produces multiple consecutive blocks per request, auto-incrementing the block counter; the downstream XOR stage consumes `ks_data`.

## Interface
- `ROUNDS`, 20: total rounds; must be even and ≥2. Each round is 4 quarter-rounds.
- `clk  in  1`: single clock, all logic rising-edge.
- `rst  in  1`: asynchronous, active-low reset.
- `start  in  1`: request; sampled only in IDLE.
- `key  in  256`: key words; `key[32*i+31:32*i]` → state word 4+i.
- `nonce  in  96`: `nonce[32*i+31:32*i]` → state word 13+i.
- `ctr_init  in  32`: block counter for the first block → state word 12.
- `num_blocks  in  16`: blocks to produce for this request.
- `ks_ready  in  1`: downstream accepts `ks_data`.
- `busy  out  1`: high from the cycle after start acceptance until return to IDLE.
- `ks_valid  out  1`: keystream block available.
- `ks_data  out  512`: `{x15,…,x0}`, word 0 in `[31:0]`.
- `done  out  1`: one-cycle pulse when the request completes.
- `ctr_wrap  out  1`: one-cycle pulse when the block counter wraps `FFFF_FFFF`→0.

## Operation
- **Initial state matrix:** words 0–3 = `61707865`, `3320646e`, `79622d32`, `6b206574`; words 4–11 = key; word 12 = counter; words 13–15 = nonce.
- **IDLE:**
  - If `start`=1, capture `key`, `nonce`, `ctr_init` and `num_blocks` into internal registers; later input changes are ignored.
  - If captured `num_blocks`=0, go to FIN, which pulses `done` and returns to IDLE; no block is produced.
  - Otherwise go to LOAD.
- **LOAD (1 cycle):** write the initial matrix into working state `x[0..15]` and keep a copy in `init[0..15]`. Clear `qr_idx` and `round`, then go to ROUND.
- **ROUND (4·ROUNDS cycles):** one quarter-round per cycle on 4 words of `x`.
  - Even rounds (column): (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15) for `qr_idx` 0–3.
  - Odd rounds (diagonal): (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
  - After `qr_idx`=3 of the last round, go to ADD.
- **ADD (1 cycle):** `ks_data[i] ← x[i] + init[i]` mod 2^32, then go to OUT.
- **OUT:**
  - Hold `ks_valid`=1 with `ks_data` stable until `ks_valid & ks_ready`.
  - On the handshake, increment the counter mod 2^32 (pulse `ctr_wrap` on wrap) and decrement the remaining-block count.
  - If blocks remain, go to LOAD with the new counter; otherwise go to FIN.
- **FIN (1 cycle):** `done`=1 and `busy`=0, then go to IDLE.
- **Quarter-round arithmetic:** all additions are mod 2^32; rotate constants are 16, 12, 8, 7.
- **start while busy:** ignored; no queuing.

## Timing
- **Reset values:** `busy`, `ks_valid`, `done`, `ctr_wrap` = 0; `ks_data` = 0; state = IDLE; all registers cleared.
- **Reset mid-operation:** immediately return to IDLE. Any in-flight block is lost and no `done` is issued.
- **First block latency:** start sampled at edge E → `ks_valid` rises after edge E+2+4·ROUNDS (E+82 for 20 rounds).
- **Block-to-block:** after a handshake at edge H with blocks remaining, the next `ks_valid` rises after edge H+2+4·ROUNDS. Without back-pressure, throughput is one block per 83 cycles.
- **Back-pressure:** with `ks_ready`=0, `ks_valid` and `ks_data` are held indefinitely. Counter and state do not advance.
- **ctr_wrap:** registered, asserted in the cycle after the wrapping handshake.
- **done:** asserted in the cycle after the final handshake. For `num_blocks`=0 it is asserted in the cycle after the start edge.

## Structure
- **Package `chacha_pkg`:**
  - The 4 sigma constants.
  - The 8×4 quarter-round index table.
  - Rotate amounts.
  - FSM state enum: IDLE, LOAD, ROUND, ADD, OUT, FIN.
- **Sub-module `chacha_qr`:** combinational 32-bit quarter-round, `(a,b,c,d)` → `(a',b',c',d')`. Exactly one instance is shared across all rounds, with a 4-of-16 mux in front and a write-back demux behind.

## Test plan
- **RFC 8439 §2.3.2 vector:**
  - Stimulus: key bytes 00..1f (`key[31:0]`=`03020100`), nonce = `{00000000, 4a000000, 09000000}`, `ctr_init`=1, `num_blocks`=1, `ks_ready`=1.
  - Required: `ks_data[31:0]`=`e4e7f110` and `ks_data[63:32]`=`15593bd1`, `ks_valid` at E+82, then `done` one cycle later.
- **Multi-block:** same key/nonce, `num_blocks`=3, `ctr_init`=1 → three blocks whose values match the reference model for counters 1, 2, 3; consecutive `ks_valid` rises exactly 83 cycles apart.
- **Back-pressure:** hold `ks_ready`=0 for 50 cycles in OUT → `ks_data` unchanged and no counter advance; the block is accepted on the first `ks_ready`=1 edge.
- **Counter wrap:** `ctr_init`=`FFFF_FFFF`, `num_blocks`=2 → second block uses counter 0 and `ctr_wrap` pulses once after the first handshake.
- **Edge requests:**
  - `num_blocks`=0 → `done` pulse at E+1 with `ks_valid` never asserted.
  - `start` pulsed mid-ROUND → ignored, output unchanged.
- **Reset mid-operation:** assert `rst`=0 at cycle 40 of ROUND → all outputs 0 at once. After release, a fresh request reproduces the RFC vector.
